// File: rtl/datapath_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : datapath_run_ctrl
// Description : Run/step/halt sequencer producing the Datapath commit enable,
//               with debounced step button, PC breakpoint and commit counter.
// Revision    : 1.0  initial release
// ============================================================================
module datapath_run_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int RUN_DIV         = 0,
    parameter int CNT_W           = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Stop,
    input  logic             StepBtn,
    input  logic             BreakEn,
    input  logic [31:0]      BreakAddr,
    input  logic [31:0]      PCResult,
    input  logic             HaltFlag,
    output logic             DpEnable,
    output logic             Running,
    output logic             Halted,
    output logic [1:0]       StateOut,
    output logic [CNT_W-1:0] StepCount
);

    localparam int c_DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int c_DIV_W = (RUN_DIV > 0) ? $clog2(RUN_DIV + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_STEP = 2'd2,
        S_HALT = 2'd3
    } state_t;

    state_t             r_state;
    logic [c_DIV_W-1:0] r_div;
    logic               r_skip;
    logic [CNT_W-1:0]   r_step_count;
    logic               r_sync1;
    logic               r_sync2;
    logic [c_DB_W-1:0]  r_db_cnt;
    logic               r_db_val;
    logic               r_db_prev;

    logic               w_step_req;
    logic               w_bp_hit;
    logic               w_dp_en;

    // Button path: two-flop synchroniser, then a level must persist for
    // DEBOUNCE_CYCLES consecutive samples before it is accepted.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_db_cnt  <= '0;
            r_db_val  <= 1'b0;
            r_db_prev <= 1'b0;
        end else begin
            r_sync1   <= StepBtn;
            r_sync2   <= r_sync1;
            r_db_prev <= r_db_val;
            if (r_sync2 != r_db_val) begin
                if (r_db_cnt == c_DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    r_db_val <= r_sync2;
                    r_db_cnt <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + 1'b1;
                end
            end else begin
                r_db_cnt <= '0;
            end
        end
    end

    assign w_step_req = r_db_val & ~r_db_prev;

    always_comb begin
        w_bp_hit = BreakEn && (PCResult == BreakAddr) && !r_skip;
        w_dp_en  = 1'b0;
        case (r_state)
            S_STEP:  w_dp_en = 1'b1;
            S_RUN:   w_dp_en = (r_div == '0) && !Stop && !HaltFlag && !w_bp_hit;
            default: w_dp_en = 1'b0;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state      <= S_IDLE;
            r_div        <= '0;
            r_skip       <= 1'b0;
            r_step_count <= '0;
        end else begin
            if (w_dp_en && (r_step_count != {CNT_W{1'b1}})) begin
                r_step_count <= r_step_count + 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (!Stop && Start) begin
                        r_state <= S_RUN;
                        r_div   <= '0;
                        r_skip  <= 1'b1;
                    end else if (!Stop && w_step_req) begin
                        r_state <= S_STEP;
                    end
                end
                S_RUN: begin
                    if (Stop) begin
                        r_state <= S_IDLE;
                    end else if (HaltFlag || w_bp_hit) begin
                        r_state <= S_HALT;
                    end else begin
                        // Skip guards only the first commit after entering RUN.
                        if (w_dp_en) begin
                            r_skip <= 1'b0;
                        end
                        r_div <= (r_div == c_DIV_W'(RUN_DIV)) ? '0 : r_div + 1'b1;
                    end
                end
                S_STEP: begin
                    r_state <= (!Stop && HaltFlag) ? S_HALT : S_IDLE;
                end
                default: begin
                    if (Stop) begin
                        r_state <= S_IDLE;
                    end else if (!HaltFlag && Start) begin
                        r_state <= S_RUN;
                        r_div   <= '0;
                        r_skip  <= 1'b1;
                    end else if (!HaltFlag && w_step_req) begin
                        r_state <= S_STEP;
                    end
                end
            endcase
        end
    end

    assign DpEnable  = w_dp_en;
    assign Running   = (r_state == S_RUN);
    assign Halted    = (r_state == S_HALT);
    assign StateOut  = r_state;
    assign StepCount = r_step_count;

endmodule
`default_nettype wire

// File: tb/tb_datapath_run_ctrl.sv
`default_nettype none
// Scoreboard bench: two controllers (RUN_DIV 0 / 3, counter 32 / 6 bits) share
// the stimulus; a reference model queues expected outputs, a monitor checks.
module tb_datapath_run_ctrl;

    localparam int DB = 16;

    logic        clk = 1'b0;
    logic        rst, start, stop, btn, ben, halt;
    logic [31:0] baddr, pc;
    logic        en0, run0, hlt0, en3, run3, hlt3;
    logic [1:0]  st0, st3;
    logic [31:0] cnt0;
    logic [5:0]  cnt3;

    always #5 clk = ~clk;

    datapath_run_ctrl #(.DEBOUNCE_CYCLES(DB), .RUN_DIV(0), .CNT_W(32)) u_dut0 (
        .Clk(clk), .Reset(rst), .Start(start), .Stop(stop), .StepBtn(btn),
        .BreakEn(ben), .BreakAddr(baddr), .PCResult(pc), .HaltFlag(halt),
        .DpEnable(en0), .Running(run0), .Halted(hlt0), .StateOut(st0), .StepCount(cnt0));

    datapath_run_ctrl #(.DEBOUNCE_CYCLES(DB), .RUN_DIV(3), .CNT_W(6)) u_dut3 (
        .Clk(clk), .Reset(rst), .Start(start), .Stop(stop), .StepBtn(btn),
        .BreakEn(ben), .BreakAddr(baddr), .PCResult(pc), .HaltFlag(halt),
        .DpEnable(en3), .Running(run3), .Halted(hlt3), .StateOut(st3), .StepCount(cnt3));

    typedef struct packed {
        logic [1:0]  st;
        logic        en;
        logic [31:0] cnt;
    } exp_t;

    exp_t q0[$];
    exp_t q3[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model state
    bit          s1, s2, db, dbp;
    bit          hist[$];
    int          m_st[2];
    int          m_div[2];
    bit          m_skip[2];
    logic [31:0] m_cnt[2];
    bit          last_en0;

    function automatic int rdiv(input int i);
        return (i == 0) ? 0 : 3;
    endfunction

    function automatic logic [31:0] cmax(input int i);
        return (i == 0) ? 32'hFFFF_FFFF : 32'd63;
    endfunction

    task automatic model_reset();
        s1 = 0; s2 = 0; db = 0; dbp = 0;
        hist.delete();
        for (int i = 0; i < 2; i++) begin
            m_st[i] = 0; m_div[i] = 0; m_skip[i] = 0; m_cnt[i] = 0;
        end
    endtask

    task automatic enter_run(input int i);
        m_st[i] = 1; m_div[i] = 0; m_skip[i] = 1;
    endtask

    // Predict this cycle's outputs from the inputs already applied, advance
    // the model past the next rising edge, then wait for that edge.
    task automatic cycle();
        bit   sreq, bp, en, tog;
        exp_t e;
        sreq = db && !dbp;
        for (int i = 0; i < 2; i++) begin
            bp = ben && (pc == baddr) && !m_skip[i];
            en = (m_st[i] == 2) || (m_st[i] == 1 && m_div[i] == 0 && !stop && !halt && !bp);
            e.st = 2'(m_st[i]); e.en = en; e.cnt = m_cnt[i];
            if (i == 0) begin
                q0.push_back(e);
                last_en0 = en;
            end else begin
                q3.push_back(e);
            end
            if (!rst) begin
                if (en && m_cnt[i] != cmax(i)) m_cnt[i] = m_cnt[i] + 1;
                case (m_st[i])
                    0: if (!stop && start) enter_run(i);
                       else if (!stop && sreq) m_st[i] = 2;
                    1: if (stop) m_st[i] = 0;
                       else if (halt || bp) m_st[i] = 3;
                       else begin
                           if (en) m_skip[i] = 0;
                           m_div[i] = (m_div[i] == rdiv(i)) ? 0 : m_div[i] + 1;
                       end
                    2: m_st[i] = (!stop && halt) ? 3 : 0;
                    default: if (stop) m_st[i] = 0;
                       else if (!halt && start) enter_run(i);
                       else if (!halt && sreq) m_st[i] = 2;
                endcase
            end
        end
        if (rst) begin
            model_reset();
        end else begin
            hist.push_back(s2);
            if (hist.size() > DB) void'(hist.pop_front());
            tog = (hist.size() == DB);
            foreach (hist[k]) if (hist[k] == db) tog = 0;
            dbp = db;
            if (tog) db = !db;
            s2 = s1;
            s1 = btn;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic run_adv(input int n);
        for (int k = 0; k < n; k++) begin
            cycle();
            if (last_en0) pc = pc + 32'd4;
        end
    endtask

    task automatic pulse_start();
        start = 1; cycle(); start = 0;
    endtask

    task automatic pulse_stop();
        stop = 1; cycle(); stop = 0;
    endtask

    task automatic pulse_reset();
        rst = 1; cycle(); rst = 0;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q0.size() > 0) begin
                e = q0.pop_front();
                check("state0", {30'd0, st0}, {30'd0, e.st});
                check("dpen0", {31'd0, en0}, {31'd0, e.en});
                check("count0", cnt0, e.cnt);
                check("running0", {31'd0, run0}, {31'd0, e.st == 2'd1});
                check("halted0", {31'd0, hlt0}, {31'd0, e.st == 2'd3});
            end
            if (q3.size() > 0) begin
                e = q3.pop_front();
                check("state3", {30'd0, st3}, {30'd0, e.st});
                check("dpen3", {31'd0, en3}, {31'd0, e.en});
                check("count3", {26'd0, cnt3}, e.cnt);
                check("running3", {31'd0, run3}, {31'd0, e.st == 2'd1});
                check("halted3", {31'd0, hlt3}, {31'd0, e.st == 2'd3});
            end
        end
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int  found;
        rst = 1; start = 0; stop = 0; btn = 0; ben = 0; halt = 0;
        baddr = 32'h10; pc = 0;
        @(posedge clk);
        #1;
        model_reset();
        idle(2);
        rst = 0;

        // Free run with RUN_DIV 0 and 3, then stop.
        idle(1);
        pulse_start();
        run_adv(12);
        pulse_stop();
        idle(2);

        // Breakpoint at 0x10, then resume past it.
        pulse_reset();
        pc = 0; ben = 1;
        pulse_start();
        run_adv(10);
        start = 1; cycle(); start = 0;
        if (last_en0) pc = pc + 32'd4;
        run_adv(3);
        pulse_stop();
        ben = 0;
        idle(2);

        // Bouncing button, long hold, release.
        for (int k = 0; k < 10; k++) begin
            btn = 1'($urandom % 2);
            cycle();
        end
        btn = 1; idle(40);
        btn = 0; idle(40);

        // Halt instruction while running; Start and step ignored while held.
        pulse_start();
        idle(3);
        halt = 1; idle(5);
        pulse_start();
        btn = 1; idle(25);
        btn = 0; idle(25);
        pulse_stop();
        halt = 0;
        idle(3);

        // Reset mid-RUN, then reset in the STEP cycle.
        pulse_start();
        idle(3);
        pulse_reset();
        idle(2);
        btn = 1;
        found = 0;
        for (int k = 0; k < 60 && found == 0; k++) begin
            if (m_st[0] == 2) found = 1;
            else cycle();
        end
        n_cmp++;
        if (found == 0) begin
            n_bad++;
            $display("FAIL step_reach: got 0 expected 1");
        end
        pulse_reset();
        idle(2);
        btn = 0; idle(25);

        // Long run: 6-bit counter of the divided instance saturates.
        pulse_start();
        idle(300);
        pulse_stop();
        idle(2);

        // Randomised traffic.
        for (int k = 0; k < 2500; k++) begin
            rst   = ($urandom % 400) == 0;
            start = ($urandom % 12) == 0;
            stop  = ($urandom % 30) == 0;
            if (($urandom % 40) == 0) halt = !halt;
            if (($urandom % 30) == 0) btn = !btn;
            ben   = 1'($urandom % 2);
            pc    = 32'(($urandom % 8) * 4);
            cycle();
        end
        rst = 0; start = 0; stop = 0; halt = 0; btn = 0;
        idle(2);

        @(negedge clk);
        #1;
        check("queue0_drained", q0.size(), 0);
        check("queue3_drained", q3.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/datapath_run_ctrl.md
Name: datapath_run_ctrl

Overview:
- Execution controller for the single-cycle Datapath.
- Produces a per-cycle clock-enable (DpEnable) that sequences instruction execution in free-run, single-step and halted modes.
- Supports a PC breakpoint and a halt-instruction flag, and counts executed instructions.
- Sits between board buttons/switches and the Datapath; runs on the divided clock that drives Datapath and the display.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive stable samples required before StepBtn changes its debounced value.
- RUN_DIV, 0: in RUN, DpEnable fires once every RUN_DIV+1 cycles.
- CNT_W, 32: width of StepCount.

Ports:
- Clk  in  1  controller clock (the divided clock shared with Datapath).
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  level, sampled each cycle; request free-run.
- Stop  in  1  level, sampled each cycle; request stop to IDLE.
- StepBtn  in  1  raw asynchronous push-button; one instruction per debounced press.
- BreakEn  in  1  enables the PC breakpoint.
- BreakAddr  in  32  breakpoint PC value.
- PCResult  in  32  current PC from Datapath.
- HaltFlag  in  1  Datapath decoded a halt instruction at PCResult.
- DpEnable  out  1  Datapath may commit one instruction this cycle.
- Running  out  1  state==RUN.
- Halted  out  1  state==HALT.
- StateOut  out  2  IDLE=0, RUN=1, STEP=2, HALT=3.
- StepCount  out  CNT_W  number of DpEnable cycles since reset, saturating.

Behaviour:
- One clock. Reset is synchronous and active-high.
- Reset values:
  - State IDLE; StateOut=0; DpEnable=0; Running=0; Halted=0; StepCount=0.
  - Divider count 0; skip flag 0; debouncer: synchroniser=0, stable counter=0, debounced value=0.
  - Reset overrides every other input, including mid-RUN and mid-STEP.
- Step input path:
  - StepBtn goes through a 2-FF synchroniser.
  - The debounced value toggles only after DEBOUNCE_CYCLES consecutive cycles at the new level. Any mismatch clears the counter.
  - step_req is a 1-cycle pulse on the debounced 0->1 edge. Holding the button gives exactly one step_req. Release produces none.
- DpEnable is combinational from registered state, divider count, skip flag and the current inputs:
  - STEP: DpEnable=1.
  - RUN: DpEnable=1 only if div==0, Stop=0, HaltFlag=0, and there is no breakpoint hit.
  - Breakpoint hit: BreakEn && PCResult==BreakAddr && skip==0.
- Input priority each cycle: Reset > Stop > HaltFlag > breakpoint > Start > step_req.
- IDLE:
  - Start -> RUN.
  - Otherwise step_req -> STEP.
  - Start and step_req together: RUN; step_req discarded.
- RUN:
  - Stop -> IDLE, no DpEnable that cycle.
  - HaltFlag or breakpoint hit -> HALT, no DpEnable that cycle.
  - Otherwise stay. Divider counts 0..RUN_DIV and wraps; DpEnable fires at 0.
  - step_req ignored.
- STEP:
  - Exactly one DpEnable, in the single cycle spent here. Breakpoint and HaltFlag are not checked.
  - Next state IDLE; next state HALT if Stop=0 and HaltFlag=1 in that cycle.
- HALT:
  - Start with HaltFlag=0 -> RUN.
  - Otherwise step_req with HaltFlag=0 -> STEP.
  - Stop -> IDLE.
  - While HaltFlag=1, only Stop or Reset leaves HALT.
- Resume past breakpoint:
  - The skip flag is set on every entry to RUN and cleared on the first DpEnable in RUN. Start from a breakpoint PC therefore executes that instruction.
  - The divider is cleared to 0 on every entry to RUN, so the first DpEnable occurs in the first RUN cycle.
- Latency: Start sampled in cycle N gives RUN and (RUN_DIV any value) DpEnable in cycle N+1, unless a halt condition holds.
- StepCount:
  - Increments by 1 in every cycle where DpEnable=1.
  - Holds at 2^CNT_W-1; no wrap.
- Running, Halted and StateOut are decoded directly from registered state, with no extra delay.

Test Plan:
- Reset, then Start pulse at cycle 2, RUN_DIV=0, BreakEn=0, PCResult advancing by 4 -> StateOut=1 from cycle 3; DpEnable=1 every cycle; StepCount=10 after 10 RUN cycles; Stop -> StateOut=0 next cycle, no DpEnable in the Stop cycle.
- RUN_DIV=3, run 12 cycles -> DpEnable on cycles 0,4,8 of RUN; StepCount=3.
- BreakEn=1, BreakAddr=0x10, PC 0,4,8,C,10 -> HALT with PCResult=0x10 and StepCount=4; then Start -> one DpEnable at 0x10, and RUN continues to 0x14.
- StepBtn bouncing 0/1 for 10 cycles, then held high 40 cycles (DEBOUNCE_CYCLES=16) -> exactly one STEP cycle and one DpEnable; StepCount +1; StateOut back to 0.
- HaltFlag=1 in RUN -> HALT and DpEnable=0 that cycle; Start and step_req ignored while HaltFlag=1; Stop -> IDLE.
- Reset asserted during RUN and again in the STEP cycle -> next cycle StateOut=0, StepCount=0, DpEnable=0.
